// File: rtl/cpu6502_bus_pkg.sv
// Shared definitions for the cpu6502 bus: vector addresses, open-bus value
// and the store-log entry layout.
package cpu6502_bus_pkg;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

  localparam int unsigned LOG_ENTRY_W = 24;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } log_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// Synchronous FIFO with registered head, flags and count; head_data shows the
// entry that will be popped next.
module store_log_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CW-1:0]    count_n;
  logic             push_ok_c, pop_ok_c;
  logic [WIDTH-1:0] head_n;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok_c  = pop && !empty;
    push_ok_c = push && (!full || pop_ok_c);
    rd_ptr_n  = rd_ptr + PW'(pop_ok_c);
    wr_ptr_n  = wr_ptr + PW'(push_ok_c);
    count_n   = count + CW'(push_ok_c) - CW'(pop_ok_c);
    head_n    = mem[rd_ptr_n];
    if (push_ok_c && (wr_ptr == rd_ptr_n)) begin
      head_n = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      full       <= (32'(count_n) == DEPTH);
      empty      <= (count_n == '0);
      head_valid <= (count_n != '0);
      head_data  <= head_n;
    end
  end

endmodule

// File: rtl/bus_responder6502.sv
// Memory-side responder for the cpu6502 bus: RAM/vector/status read decode,
// phi2-edge store commit, host preload port and a store log.
module bus_responder6502
  import cpu6502_bus_pkg::*;
#(
  parameter int unsigned RAM_AW       = 11,
  parameter int unsigned LOG_DEPTH    = 8,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] STATUS_ADDR  = 16'hF000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [7:0]        wdata,
  input  logic              rw,
  input  logic              clk2,
  output logic [7:0]        idata,
  input  logic              ld_we,
  input  logic [RAM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              log_valid,
  output logic [15:0]       log_addr,
  output logic [7:0]        log_data,
  input  logic              log_ready,
  output logic              log_overflow
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;
  localparam int unsigned CW        = $clog2(LOG_DEPTH) + 1;

  logic [7:0]        ram [RAM_WORDS];
  logic              clk2_q;
  logic              store_c, ram_hit_c, pop_c;
  logic              ram_we_c;
  logic [RAM_AW-1:0] ram_waddr_c;
  logic [7:0]        ram_wdata_c, rd_data_c;
  logic [2:0]        cnt_sat_c;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  log_entry_t        head;

  // Store strobe and RAM write port; a CPU store beats a host preload.
  always_comb begin
    store_c     = reset && clk2 && !clk2_q && !rw;
    ram_hit_c   = ((addr >> RAM_AW) == 16'd0);
    pop_c       = log_valid && log_ready && !fifo_empty;
    ram_we_c    = 1'b0;
    ram_waddr_c = ld_addr;
    ram_wdata_c = ld_data;
    if (store_c && ram_hit_c) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = addr[RAM_AW-1:0];
      ram_wdata_c = wdata;
    end else if (ld_we) begin
      ram_we_c = 1'b1;
    end
  end

  // Priority read decode; RAM reads are write-first.
  always_comb begin
    cnt_sat_c = (32'(fifo_count) > 32'd7) ? 3'd7 : 3'(fifo_count);
    rd_data_c = OPEN_BUS_DATA;
    if (ram_hit_c) begin
      rd_data_c = ram[addr[RAM_AW-1:0]];
      if (ram_we_c && (ram_waddr_c == addr[RAM_AW-1:0])) begin
        rd_data_c = ram_wdata_c;
      end
    end else if (addr == VEC_RESET) begin
      rd_data_c = RESET_VECTOR[7:0];
    end else if (addr == (VEC_RESET | 16'h0001)) begin
      rd_data_c = RESET_VECTOR[15:8];
    end else if (addr == STATUS_ADDR) begin
      rd_data_c = {log_overflow, log_valid, 3'b000, cnt_sat_c};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram[ram_waddr_c] <= ram_wdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk2_q       <= 1'b1;
      idata        <= OPEN_BUS_DATA;
      log_overflow <= 1'b0;
    end else begin
      clk2_q <= clk2;
      idata  <= rd_data_c;
      if (store_c && fifo_full && !pop_c) begin
        log_overflow <= 1'b1;
      end
    end
  end

  store_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LOG_ENTRY_W)
  ) u_log (
    .clk        (clk),
    .reset      (reset),
    .push       (store_c),
    .pop        (pop_c),
    .din        ({addr, wdata}),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_valid (log_valid),
    .head_data  (head)
  );

  assign log_addr = head.addr;
  assign log_data = head.data;

endmodule

// File: tb/tb_bus_responder6502.sv
// Directed bench for bus_responder6502: expected loads and log entries are
// queued at issue time and compared by an independent monitor.
module tb_bus_responder6502;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        rw = 1'b1;
  logic        clk2 = 1'b0;
  logic [7:0]  idata;
  logic        ld_we = 1'b0;
  logic [10:0] ld_addr = 11'h000;
  logic [7:0]  ld_data = 8'h00;
  logic        log_valid;
  logic [15:0] log_addr;
  logic [7:0]  log_data;
  logic        log_ready = 1'b0;
  logic        log_overflow;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0]  exp_rd [$];
  logic [23:0] exp_log [$];
  logic        rd_chk = 1'b0;
  logic        rd_pend = 1'b0;
  logic [7:0]  prog [6];

  always #5 clk = ~clk;

  bus_responder6502 #(
    .RAM_AW       (11),
    .LOG_DEPTH    (8),
    .RESET_VECTOR (16'h0200),
    .STATUS_ADDR  (16'hF000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .wdata        (wdata),
    .rw           (rw),
    .clk2         (clk2),
    .idata        (idata),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .log_valid    (log_valid),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_ready    (log_ready),
    .log_overflow (log_overflow)
  );

  always @(posedge clk) rd_pend <= rd_chk;

  // Monitor: loads one clk after issue, log entries whenever one is popped.
  always @(negedge clk) begin
    logic [7:0]  e_rd;
    logic [23:0] e_log;
    if (rd_pend) begin
      n_vec++;
      if (exp_rd.size() == 0) begin
        n_miss++;
        $display("FAIL load: idata=%02h with no expected value queued", idata);
      end else begin
        e_rd = exp_rd.pop_front();
        if (idata !== e_rd) begin
          n_miss++;
          $display("FAIL load: idata=%02h expected %02h", idata, e_rd);
        end
      end
    end
    if (log_valid && log_ready) begin
      n_vec++;
      if (exp_log.size() == 0) begin
        n_miss++;
        $display("FAIL log: got %04h/%02h with no expected entry", log_addr, log_data);
      end else begin
        e_log = exp_log.pop_front();
        if ({log_addr, log_data} !== e_log) begin
          n_miss++;
          $display("FAIL log: got %04h/%02h expected %04h/%02h",
                   log_addr, log_data, e_log[23:8], e_log[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] e);
    addr = a;
    rw = 1'b1;
    exp_rd.push_back(e);
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
  endtask

  // One bus cycle: phi2 low, phi2 high (strobe cycle), phi2 low.
  task automatic do_store(input logic [15:0] a, input logic [7:0] d, input logic logged,
                          input logic clash, input logic [7:0] hd, input logic pop_now);
    addr = a;
    wdata = d;
    rw = 1'b0;
    clk2 = 1'b0;
    tick();
    clk2 = 1'b1;
    if (clash) begin
      ld_we = 1'b1;
      ld_addr = a[10:0];
      ld_data = hd;
    end
    if (pop_now) log_ready = 1'b1;
    if (logged) exp_log.push_back({a, d});
    tick();
    if (pop_now) log_ready = 1'b0;
    ld_we = 1'b0;
    clk2 = 1'b0;
    rw = 1'b1;
    tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    log_ready = 1'b1;
    while (exp_log.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    chk("drain_left", 32'(exp_log.size()), 32'd0);
    chk("drain_valid", 32'(log_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog = '{8'hA9, 8'h00, 8'h09, 8'h84, 8'h85, 8'h99};

    // Preload the program while in reset, plus a marker byte at $0030.
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      ld_we = 1'b1;
      ld_addr = 11'(i);
      ld_data = prog[i];
      tick();
    end
    ld_addr = 11'h030;
    ld_data = 8'h11;
    tick();
    ld_we = 1'b0;
    tick();
    chk("rst_idata", 32'(idata), 32'hFF);
    chk("rst_valid", 32'(log_valid), 32'd0);
    chk("rst_addr", 32'(log_addr), 32'd0);
    chk("rst_data", 32'(log_data), 32'd0);
    chk("rst_ovf", 32'(log_overflow), 32'd0);

    // Program fetch and its single store (STA $99 of $84).
    reset = 1'b1;
    log_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) do_read(16'(i), prog[i]);
    do_read(16'hF000, 8'h00);
    do_store(16'h0099, 8'h84, 1'b1, 1'b0, 8'h00, 1'b0);
    do_read(16'h0099, 8'h84);
    drain();

    // Vectors, open bus and RAM boundary.
    do_read(16'hFFFC, 8'h00);
    do_read(16'hFFFD, 8'h02);
    do_read(16'h8000, 8'hFF);
    do_store(16'h07FF, 8'hE1, 1'b1, 1'b0, 8'h00, 1'b0);
    do_read(16'h07FF, 8'hE1);
    do_store(16'h0800, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0);
    do_read(16'h0800, 8'hFF);
    do_store(16'hFFFC, 8'h34, 1'b1, 1'b0, 8'h00, 1'b0);
    do_read(16'hFFFC, 8'h00);

    // CPU store and host preload to the same address in the same cycle.
    do_store(16'h0010, 8'hAA, 1'b1, 1'b1, 8'h55, 1'b0);
    do_read(16'h0010, 8'hAA);
    drain();

    // Ten stores into an eight-entry log with no pops.
    log_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_store(16'h0100 + 16'(i), 8'h30 + 8'(i), (i < 8), 1'b0, 8'h00, 1'b0);
    end
    do_read(16'hF000, 8'hC7);
    chk("ovf_set", 32'(log_overflow), 32'd1);
    drain();

    // Reset mid-run with three entries logged and a strobe in the reset cycle.
    log_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_store(16'h0180 + 16'(i), 8'h60 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
    end
    do_read(16'hF000, 8'hC3);
    addr = 16'h0030;
    wdata = 8'h77;
    rw = 1'b0;
    clk2 = 1'b0;
    tick();
    clk2 = 1'b1;
    reset = 1'b0;
    tick();
    exp_log.delete();
    chk("mid_rst_valid", 32'(log_valid), 32'd0);
    chk("mid_rst_ovf", 32'(log_overflow), 32'd0);
    chk("mid_rst_idata", 32'(idata), 32'hFF);
    clk2 = 1'b0;
    rw = 1'b1;
    reset = 1'b1;
    tick();
    do_read(16'hF000, 8'h00);
    do_read(16'h0030, 8'h11);
    do_read(16'h0010, 8'hAA);
    do_read(16'h0099, 8'h84);

    // Full log: pop and push in the same cycle.
    for (int i = 0; i < 8; i++) begin
      do_store(16'h0200 + 16'(i), 8'h40 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
    end
    do_read(16'hF000, 8'h47);
    do_store(16'h0210, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
    do_read(16'hF000, 8'h47);
    chk("full_pop_ovf", 32'(log_overflow), 32'd0);
    drain();

    tick();
    tick();
    chk("loads_left", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
